fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin burst arbiter that shares one write port of the 24-bit sample FIFO among several producers (audio channels, tone generators, test-pattern sources). It sits directly in front of the FIFO's `wr`/`w_data`/`full` interface, grants one requester at a time for a bounded burst, and tags every accepted word with its source index. Per-source word counters support debug and bench checking.

## Interface
Parameters:
- `DATA_WIDTH`, 24, bits per sample word; matches FIFO `DATA_WIDTH`.
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `BURST_LEN`, 4, maximum consecutive words granted to one owner; legal range 1..255.
- `TAG_W`, `$clog2(NUM_REQ)`, derived width of the source tag.

Ports (single clock; reset is synchronous, active-high):
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-source "word available"; held until acked.
- `req_data`  in  NUM_REQ×DATA_WIDTH  packed `[NUM_REQ-1:0][DATA_WIDTH-1:0]` word per source.
- `ack`  out  NUM_REQ  one-hot, combinational; high in the cycle the source's word is written.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_wr`  out  1  FIFO `wr`, combinational.
- `fifo_w_data`  out  DATA_WIDTH  FIFO `w_data`; mux of the owner's `req_data`.
- `fifo_w_tag`  out  TAG_W  owner index, valid when `fifo_wr` is high.
- `busy`  out  1  registered; high in BURST state.
- `word_cnt`  out  NUM_REQ×16  per-source accepted-word counters, wrapping.

## Operation
- FSM states: IDLE, BURST. Registers: `state`, `owner`, `rr_ptr`, `beat_cnt` (8 bits), `word_cnt`.
- IDLE: `fifo_wr`=0, `ack`=0. If any `req` is high, the winner is the first set bit scanning upward from `rr_ptr` with wrap-around. Next: BURST, `owner`=winner, `beat_cnt`=0. `fifo_full` does not block the grant.
- BURST: `fifo_wr` = `req[owner]` & ~`fifo_full`. `ack[owner]` = `fifo_wr`. `fifo_w_data` = `req_data[owner]`. `fifo_w_tag` = `owner`.
- On each write: `beat_cnt`++ and `word_cnt[owner]`++ (wraps 0xFFFF→0).
- BURST exits to IDLE with `rr_ptr` = (`owner`+1) mod NUM_REQ when either:
  - a write occurs with `beat_cnt` == BURST_LEN-1, or
  - `req[owner]` is low.
- `fifo_full` high in BURST: no write, no ack, `beat_cnt` frozen, state held. A burst is never aborted by full.
- Requests from non-owners are ignored until the next IDLE arbitration. No preemption.
- The FIFO write is never issued while `fifo_full`=1, so no word is lost and a requester's word is consumed only when `ack` is high.

## Timing
- Reset values: `state`=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0, all `word_cnt`=0. Outputs: `fifo_wr`=0, `ack`=0, `busy`=0, `fifo_w_tag`=0, `fifo_w_data`=`req_data[0]` (don't-care).
- Reset mid-burst abandons the burst. No ack is issued in the reset cycle.
- Grant latency: `req` rising in IDLE at edge N gives the first write in cycle N+1. There is always exactly one IDLE cycle between bursts.
- Sustained throughput with all sources requesting and FIFO never full: BURST_LEN words per BURST_LEN+1 cycles.
- Simultaneous full deassert and `req` drop: the drop wins and the FSM goes to IDLE with no write.
- `ack` and `fifo_wr` are combinational from `fifo_full` and `req`, so the FIFO must present `full` as a registered signal to avoid loops.

## Structure
- Shared package `fifo_arb_pkg`:
  - `typedef enum logic {IDLE, BURST} arb_state_t`
  - `localparam CNT_W = 16`
  - function `rr_pick(req, ptr)` returning the winner index.
- One sub-module is natural: `rr_picker`, a combinational rotating priority encoder that is parameterised by NUM_REQ and outputs `found` and `idx`.
- Top instantiates `rr_picker`. The parent wires `fifo_arb_pkg`-typed state, `fifo_wr`/`fifo_w_data` to `fifo.wr`/`fifo.w_data`, and `fifo.full` to `fifo_full`.

## Test plan
- Reset with `req`=4'b1111 held → `fifo_wr`=0, `busy`=0, all `word_cnt`=0. Release at edge R → first write at R+1 with tag 0.
- `req`=4'b1111, FIFO never full, BURST_LEN=4, 40 cycles → tags 0,0,0,0,1,1,1,1,2,… with one idle cycle between groups. Each `word_cnt` ≥ 7.
- Only `req[2]` high, data incrementing 0x000001.. on each ack → tags all 2, data 1,2,3,4 then gap, then 5,… No word is repeated or skipped.
- `fifo_full` forced high for 3 cycles after the second beat of a source-1 burst → no `ack` during full. Beats 3 and 4 follow after release, then rotate to source 2.
- `req[3]` drops after 2 beats with `req`=4'b1001 → IDLE, then grant goes to source 0 (wrap-around). `word_cnt[3]`=2.
- Reset asserted mid-burst at beat 2 → `busy`=0 next cycle, `rr_ptr`=0, counters cleared, and no write during reset.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of each per-source accepted-word counter.
  localparam int CNT_W = 16;

  // Widest requester vector the round-robin helper supports.
  localparam int MAX_REQ = 8;

  // Round-robin pick: first set bit of req at or above ptr, wrapping at n.
  // Returns ptr unchanged when no bit is set; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] win;
    logic       hit;
    int         cand;
    win = ptr;
    hit = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = (int'(ptr) + k) % n;
      if (!hit && (k < n) && req[cand[2:0]]) begin
        win = cand[2:0];
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating priority encoder: finds the first active request
// starting at the round-robin pointer and wrapping past the top index.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic               found,
  output logic [TAG_W-1:0]   idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         win;

  // Widen to the helper's fixed width and select the winner.
  always_comb begin
    req_ext = MAX_REQ'(req);
    ptr_ext = 3'(ptr);
    win     = rr_pick(req_ext, ptr_ext, NUM_REQ);
    found   = |req;
    idx     = TAG_W'(win);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the sample FIFO write port. One
// requester owns the port for up to BURST_LEN words; every accepted word
// carries its source index, and per-source counters track accepted words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int TAG_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  ack,
  input  logic                                fifo_full,
  output logic                                fifo_wr,
  output logic [DATA_WIDTH-1:0]               fifo_w_data,
  output logic [TAG_W-1:0]                    fifo_w_tag,
  output logic                                busy,
  output logic [NUM_REQ-1:0][CNT_W-1:0]       word_cnt
);

  arb_state_t       state;
  logic [TAG_W-1:0] owner;
  logic [TAG_W-1:0] rr_ptr;
  logic [7:0]       beat_cnt;

  logic             pick_found;
  logic [TAG_W-1:0] pick_idx;
  logic             owner_req;
  logic             wr_en;
  logic             last_beat;
  logic [TAG_W-1:0] next_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Write qualification and FIFO-side outputs. Reset gates the write so a
  // burst interrupted by reset never consumes a word in the reset cycle.
  always_comb begin
    owner_req   = req[owner];
    wr_en       = (state == BURST) && !reset && owner_req && !fifo_full;
    last_beat   = (beat_cnt == 8'(BURST_LEN - 1));
    next_ptr    = (owner == TAG_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    fifo_wr     = wr_en;
    ack         = wr_en ? (NUM_REQ'(1) << owner) : '0;
    fifo_w_data = req_data[owner];
    fifo_w_tag  = owner;
    busy        = (state == BURST);
  end

  // Arbitration FSM: grant in IDLE, stream the owner's words in BURST.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BURST;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          // A dropped request ends the burst even if full just released.
          if (!owner_req) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (wr_en) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-source accepted-word counters, wrapping at the counter width.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (wr_en) begin
      word_cnt[owner] <= word_cnt[owner] + CNT_W'(1);
    end
  end

endmodule
